// File: rtl/ahbl_two_port_master_arb.sv
// Round-robin arbiter that turns commands from two requesters into single
// non-pipelined AHB-Lite SINGLE/NONSEQ transfers on one master port.
module ahbl_two_port_master_arb #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        HCLK,
    input  logic        HRESETN,
    input  logic        REQ0,
    input  logic        REQ1,
    input  logic        WR0,
    input  logic        WR1,
    input  logic [31:0] ADDR0,
    input  logic [31:0] ADDR1,
    input  logic [2:0]  SIZE0,
    input  logic [2:0]  SIZE1,
    input  logic [31:0] WDATA0,
    input  logic [31:0] WDATA1,
    output logic        GNT0,
    output logic        GNT1,
    output logic        DONE0,
    output logic        DONE1,
    output logic [31:0] RDATA,
    output logic        ERR,
    output logic        TIMEOUT,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    // Counter is wide enough to reach TIMEOUT_CYCLES before it saturates.
    localparam int unsigned      CNT_W  = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

    state_t             state_q,   state_d;
    logic               last_q,    last_d;
    logic               owner_q,   owner_d;
    logic [31:0]        haddr_q,   haddr_d;
    logic               hwrite_q,  hwrite_d;
    logic [2:0]         hsize_q,   hsize_d;
    logic [31:0]        wdata_q,   wdata_d;
    logic               gnt0_q,    gnt0_d;
    logic               gnt1_q,    gnt1_d;
    logic               done0_q,   done0_d;
    logic               done1_q,   done1_d;
    logic [31:0]        rdata_q,   rdata_d;
    logic               err_q,     err_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   wait_q,    wait_d;
    logic [CNT_W-1:0]   wait_inc;

    logic        win;
    logic        sel_wr;
    logic [31:0] sel_addr;
    logic [2:0]  sel_size;
    logic [31:0] sel_wdata;
    logic        sel_bad;

    // Winner is the sole requester, or the port that did not win last time.
    always_comb begin
        win       = (REQ0 & REQ1) ? ~last_q : REQ1;
        sel_wr    = win ? WR1    : WR0;
        sel_addr  = win ? ADDR1  : ADDR0;
        sel_size  = win ? SIZE1  : SIZE0;
        sel_wdata = win ? WDATA1 : WDATA0;
        sel_bad   = (sel_size > 3'd2)
                  | ((sel_size == 3'd1) & sel_addr[0])
                  | ((sel_size == 3'd2) & (|sel_addr[1:0]));
    end

    assign wait_inc = wait_q + 1'b1;

    always_comb begin
        // NOTE: every signal gets its default first so no path can infer a latch.
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        haddr_d   = haddr_q;
        hwrite_d  = hwrite_q;
        hsize_d   = hsize_q;
        wdata_d   = wdata_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        rdata_d   = rdata_q;
        err_d     = err_q;
        timeout_d = timeout_q;
        wait_d    = wait_q;

        case (state_q)
            S_IDLE: begin
                if (REQ0 | REQ1) begin
                    last_d = win;
                    gnt0_d = ~win;
                    gnt1_d = win;
                    if (sel_bad) begin
                        // Rejected command completes at once without touching the bus.
                        done0_d = ~win;
                        done1_d = win;
                        err_d   = 1'b1;
                    end else begin
                        owner_d  = win;
                        haddr_d  = sel_addr;
                        hwrite_d = sel_wr;
                        hsize_d  = sel_size;
                        wdata_d  = sel_wdata;
                        state_d  = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (HREADY) begin
                    wait_d  = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (HREADY) begin
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                    if (!hwrite_q) begin
                        rdata_d = HRDATA;
                    end
                    err_d   = HRESP;
                    state_d = S_IDLE;
                end else begin
                    if (wait_q != '1) begin
                        wait_d = wait_inc;
                    end
                    if ((TIMEOUT_CYCLES != 0) && (wait_inc == TO_LIM)) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state_q   <= S_IDLE;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            haddr_q   <= '0;
            hwrite_q  <= 1'b0;
            hsize_q   <= '0;
            wdata_q   <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            haddr_q   <= haddr_d;
            hwrite_q  <= hwrite_d;
            hsize_q   <= hsize_d;
            wdata_q   <= wdata_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
            wait_q    <= wait_d;
        end
    end

    assign GNT0      = gnt0_q;
    assign GNT1      = gnt1_q;
    assign DONE0     = done0_q;
    assign DONE1     = done1_q;
    assign RDATA     = rdata_q;
    assign ERR       = err_q;
    assign TIMEOUT   = timeout_q;
    assign HADDR     = haddr_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HTRANS    = (state_q == S_ADDR) ? 2'b10 : 2'b00;
    assign HWDATA    = ((state_q == S_DATA) && hwrite_q) ? wdata_q : 32'h0;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;

endmodule
